// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the ALU-only RV32I datapath: fetches over a req/ack port,
// steps DECODE/EXEC/WB, gates writeback, advances the PC and retires instructions.
module alu_seq_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT   = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] iaddr,
  input  logic        imem_ack,
  input  logic [31:0] idata,
  output logic [31:0] instr_q,
  output logic        alu_en,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        illegal,
  output logic        bus_err,
  output logic        halted
);

  localparam int          CW        = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(FETCH_TIMEOUT - 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [31:0]   pc_r;
  logic [31:0]   instret_r;
  logic [31:0]   instr_r;
  logic [CW-1:0] cnt_r;
  logic          legal_r;
  logic          illegal_r;
  logic          bus_err_r;
  logic          run_s;

  // Only OP-IMM and OP are executed by this ALU-only datapath.
  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == 7'b0010011) || (op == 7'b0110011);
  endfunction

  // Pulses are suppressed while stalled or while reset is being applied.
  assign run_s    = !reset && !hold;
  assign imem_req = run_s && (state_r == S_FETCH);
  assign alu_en   = run_s && (state_r == S_EXEC);
  assign rf_we    = run_s && (state_r == S_WB) && legal_r && (instr_r[11:7] != 5'd0);
  assign iaddr    = pc_r;
  assign instr_q  = instr_r;
  assign pc       = pc_r;
  assign instret  = instret_r;
  assign illegal  = illegal_r;
  assign bus_err  = bus_err_r;
  assign halted   = (state_r == S_HALT);

  // Next-state decode; an ack in the last timeout cycle still wins.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   state_s = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_s = S_DECODE;
        end else if (cnt_r == TO_LAST) begin
          state_s = S_HALT;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: state_s = S_EXEC;
      S_EXEC:   state_s = S_WB;
      S_WB: begin
        if (!legal_r && HALT_ON_ILLEGAL) begin
          state_s = S_HALT;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_HALT:   state_s = S_HALT;
      default:  state_s = S_HALT;
    endcase
  end

  // State register; hold freezes the sequence in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else if (!hold) begin
      state_r <= state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Fetch, decode and retirement bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= RESET_PC;
      instret_r <= 32'd0;
      instr_r   <= NOP_INSTR;
      cnt_r     <= {CW{1'b0}};
      legal_r   <= 1'b0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else if (!hold) begin
      case (state_r)
        S_FETCH: begin
          if (imem_ack) begin
            instr_r <= idata;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == TO_LAST) begin
            bus_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_DECODE: legal_r <= is_legal_op(instr_r[6:0]);
        S_WB: begin
          pc_r      <= pc_r + 32'd4;
          instret_r <= instret_r + 32'd1;
          if (!legal_r) begin
            illegal_r <= 1'b1;
          end else begin
            illegal_r <= illegal_r;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] idata = 32'd0;
  logic        imem_req, alu_en, rf_we, illegal, bus_err, halted;
  logic [31:0] iaddr, instr_q, pc, instret;

  alu_seq_ctrl dut (
    .clk(clk), .reset(reset), .hold(hold), .imem_req(imem_req), .iaddr(iaddr),
    .imem_ack(imem_ack), .idata(idata), .instr_q(instr_q), .alu_en(alu_en),
    .rf_we(rf_we), .pc(pc), .instret(instret), .illegal(illegal),
    .bus_err(bus_err), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_FETCH = 1, M_DEC = 2, M_EXEC = 3, M_WB = 4, M_HALT = 5;
  localparam int FT = 16;

  int checks = 0;
  int errors = 0;

  // Model: which step of an instruction we are in, plus architectural state.
  int          m_step = M_IDLE;
  int          m_wait = 0;
  logic [31:0] m_pc = 32'd0, m_ret = 32'd0, m_ins = 32'h0000_0013;
  logic        m_ill = 1'b0, m_bus = 1'b0;

  function automatic bit legal_w(input logic [31:0] w);
    return (w[6:0] == 7'h13) || (w[6:0] == 7'h33);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic compare();
    bit run;
    bit e_req;
    run   = !reset && !hold;
    e_req = run && (m_step == M_FETCH);
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) chk("iaddr", iaddr, m_pc);
    chk("alu_en", {31'd0, alu_en}, {31'd0, run && (m_step == M_EXEC)});
    chk("rf_we", {31'd0, rf_we},
        {31'd0, run && (m_step == M_WB) && legal_w(m_ins) && (m_ins[11:7] != 5'd0)});
    chk("instr_q", instr_q, m_ins);
    chk("pc", pc, m_pc);
    chk("instret", instret, m_ret);
    chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
    chk("bus_err", {31'd0, bus_err}, {31'd0, m_bus});
    chk("halted", {31'd0, halted}, {31'd0, m_step == M_HALT});
  endtask

  task automatic model_step();
    if (reset) begin
      m_step = M_IDLE; m_wait = 0; m_pc = 32'd0; m_ret = 32'd0;
      m_ins = 32'h0000_0013; m_ill = 1'b0; m_bus = 1'b0;
    end else if (!hold) begin
      case (m_step)
        M_IDLE:  m_step = M_FETCH;
        M_FETCH: begin
          if (imem_ack) begin
            m_ins = idata; m_wait = 0; m_step = M_DEC;
          end else if (m_wait == FT - 1) begin
            m_bus = 1'b1; m_step = M_HALT;
          end else begin
            m_wait++;
          end
        end
        M_DEC:   m_step = M_EXEC;
        M_EXEC:  m_step = M_WB;
        M_WB: begin
          m_pc  = m_pc + 32'd4;
          m_ret = m_ret + 32'd1;
          if (legal_w(m_ins)) m_step = M_FETCH;
          else begin m_ill = 1'b1; m_step = M_HALT; end
        end
        default: m_step = M_HALT;
      endcase
    end
  endtask

  // One clock: drive inputs on the falling edge, check, then advance the model.
  task automatic cyc(input logic r, input logic h, input logic a, input logic [31:0] d);
    @(negedge clk);
    reset = r; hold = h; imem_ack = a; idata = d;
    #1;
    compare();
    model_step();
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 19);
    if (k < 9) w[6:0] = 7'h13;
    else if (k < 18) w[6:0] = 7'h33;
    if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'd0);
    post_edge();
    chk("rst_instr_q", instr_q, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0000_0000);

    // addi x1,x0,5 with immediate ack
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t1_idle_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0050_0093);
    chk("t1_req_c1", {31'd0, imem_req}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t1_alu_c3", {31'd0, alu_en}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t1_rfwe_c4", {31'd0, rf_we}, 32'd1);
    post_edge();
    chk("t1_pc", pc, 32'd4);
    chk("t1_instret", instret, 32'd1);

    // add x0,x1,x2: executes but never writes x0
    cyc(1'b0, 1'b0, 1'b1, 32'h0020_8033);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t2_alu", {31'd0, alu_en}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t2_rfwe_x0", {31'd0, rf_we}, 32'd0);
    post_edge();
    chk("t2_pc", pc, 32'd8);
    chk("t2_instret", instret, 32'd2);

    // hold for 3 cycles in EXEC
    cyc(1'b0, 1'b0, 1'b1, 32'h0010_0113);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      chk("t5_alu_held", {31'd0, alu_en}, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t5_alu_late", {31'd0, alu_en}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t5_no_second_alu", {31'd0, alu_en}, 32'd0);
    post_edge();
    chk("t5_pc", pc, 32'd12);
    chk("t5_instret", instret, 32'd3);

    // ack arrives in the last allowed FETCH cycle
    for (int i = 0; i < FT - 1; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0030_0193);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    post_edge();
    chk("t4_late_ack_no_err", {31'd0, bus_err}, 32'd0);
    chk("t4_late_ack_pc", pc, 32'd16);

    // reset in WB, then reset in FETCH with an ack
    cyc(1'b0, 1'b0, 1'b1, 32'h0050_0093);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t6_wb_rfwe", {31'd0, rf_we}, 32'd0);
    post_edge();
    chk("t6_wb_pc", pc, 32'd0);
    chk("t6_wb_instret", instret, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t6_idle_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0050_0093);
    post_edge();
    chk("t6_fetch_instr_q", instr_q, 32'h0000_0013);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);

    // illegal opcode halts after retiring
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_006F);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    post_edge();
    chk("t3_illegal", {31'd0, illegal}, 32'd1);
    chk("t3_halted", {31'd0, halted}, 32'd1);
    chk("t3_instret", instret, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'h0050_0093);
      chk("t3_req_after_halt", {31'd0, imem_req}, 32'd0);
    end

    // fetch timeout with no ack at all
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < FT; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t4_err_not_early", {31'd0, bus_err}, 32'd0);
    post_edge();
    chk("t4_bus_err", {31'd0, bus_err}, 32'd1);
    chk("t4_halted", {31'd0, halted}, 32'd1);

    // randomized traffic against the model
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
          rand_instr());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
